// File: rtl/cordic_cos_scheduler.sv
// rtl/cordic_cos_scheduler.sv - two-requester round-robin sequencer for the iterative CORDIC cosine core
// Operands pass through untouched; the core is cleared, run for LATENCY enabled cycles, then held.
module cordic_cos_scheduler #(
  parameter int LATENCY = 10,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              req0_valid,
  input  logic [31:0]       req0_dataa,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_result,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [31:0]       req1_dataa,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_result,
  input  logic              rsp1_ready,
  output logic              core_clr,
  output logic              core_clk_en,
  output logic [31:0]       core_dataa,
  input  logic [31:0]       core_result,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [31:0]      core_dataa_q, core_dataa_d;
  logic [31:0]      rsp0_result_q, rsp0_result_d;
  logic [31:0]      rsp1_result_q, rsp1_result_d;

  logic             st_idle;
  logic             st_done;
  logic             grant0;
  logic             grant1;
  logic             rsp_taken;

  // last_q holds the requester served most recently; a tie goes to the other one.
  always_comb begin
    st_idle = (state_q == S_IDLE);
    st_done = (state_q == S_DONE);
    grant1  = req1_valid & (~req0_valid | ~last_q);
    grant0  = req0_valid & ~grant1;
    rsp_taken = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    owner_d       = owner_q;
    core_dataa_d  = core_dataa_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          core_dataa_d = grant1 ? req1_dataa : req0_dataa;
          owner_d      = grant1;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (owner_q) begin
            rsp1_result_d = core_result;
          end else begin
            rsp0_result_d = core_result;
          end
          last_d  = owner_q;
          state_d = S_DONE;
        end
      end
      default: begin
        if (rsp_taken) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      core_dataa_q  <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      core_dataa_q  <= core_dataa_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  // Ready is gated by aclr so nothing handshakes while reset is held.
  always_comb begin
    req0_ready  = st_idle & aclr & grant0;
    req1_ready  = st_idle & aclr & grant1;
    rsp0_valid  = st_done & ~owner_q;
    rsp1_valid  = st_done & owner_q;
    rsp0_result = rsp0_result_q;
    rsp1_result = rsp1_result_q;
    core_clr    = st_idle | (state_q == S_LOAD);
    core_clk_en = (state_q == S_RUN);
    core_dataa  = core_dataa_q;
    busy        = ~st_idle;
    owner       = owner_q;
  end

endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// tb/tb_cordic_cos_scheduler.sv - scoreboard bench for cordic_cos_scheduler with a stand-in core
// The stand-in core result encodes the operand and the number of enabled cycles seen.
module tb_cordic_cos_scheduler;

  localparam int LAT = 10;
  localparam logic [31:0] K = 32'h9E3779B9;

  logic        clock;
  logic        aclr;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_dataa, req1_dataa;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready, rsp1_ready;
  logic        core_clr, core_clk_en;
  logic [31:0] core_dataa, core_result;
  logic        busy, owner;

  cordic_cos_scheduler #(.LATENCY(LAT), .CNT_W(8)) dut (
    .clock(clock), .aclr(aclr),
    .req0_valid(req0_valid), .req0_dataa(req0_dataa), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_dataa(req1_dataa), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready),
    .core_clr(core_clr), .core_clk_en(core_clk_en), .core_dataa(core_dataa),
    .core_result(core_result), .busy(busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in core: cleared to the operand, counts enabled cycles.
  logic [31:0] fc_op, fc_n;
  always @(posedge clock) begin
    if (core_clr) begin
      fc_op <= core_dataa;
      fc_n  <= 32'd0;
    end else if (core_clk_en) begin
      fc_n <= fc_n + 32'd1;
    end
  end
  assign core_result = fc_op + (fc_n + 32'(core_clk_en)) * K;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ch;
    logic [31:0] res;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: who should win, and where in a job the DUT should be.
  bit   m_busy = 0;
  bit   m_last = 1;
  bit   m_owner = 0;
  int   m_cyc = 0;
  bit   g0, g1, w, m_en, m_done;
  logic [6:0] exp_v, act_v;
  exp_t e, p;

  always @(negedge clock) begin
    if (!aclr) begin
      exp_q.delete();
      m_busy = 0;
      m_last = 1;
      m_cyc  = 0;
    end else begin
      g0 = 0; g1 = 0; w = 0; m_done = 0; m_en = 0;
      if (m_busy) m_cyc++;
      if (!m_busy) begin
        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
        g0 = req0_valid && !w;
        g1 = req1_valid && w;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, g1, g0};
      end else begin
        m_en   = (m_cyc >= 2) && (m_cyc <= LAT + 1);
        m_done = (m_cyc >= LAT + 2);
        exp_v = {1'b1, !(m_cyc >= 2), m_en, m_done && m_owner, m_done && !m_owner, 1'b0, 1'b0};
      end
      act_v = {busy, core_clr, core_clk_en, rsp1_valid, rsp0_valid, req1_ready, req0_ready};
      chk("ctl_vector", 32'(act_v), 32'(exp_v));

      if (m_done && exp_q.size() > 0)
        chk("rsp_hold", m_owner ? rsp1_result : rsp0_result, exp_q[0].res);

      if (rsp0_valid && rsp0_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got response on ch0 expected none");
        end else begin
          p = exp_q.pop_front();
          chk("sb_ch0_owner", 32'(p.ch), 32'd0);
          chk("sb_ch0_result", rsp0_result, p.res);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got response on ch1 expected none");
        end else begin
          p = exp_q.pop_front();
          chk("sb_ch1_owner", 32'(p.ch), 32'd1);
          chk("sb_ch1_result", rsp1_result, p.res);
        end
      end

      if (!m_busy && (g0 || g1)) begin
        e.ch  = w;
        e.res = (w ? req1_dataa : req0_dataa) + 32'(LAT) * K;
        exp_q.push_back(e);
        m_busy  = 1;
        m_cyc   = 0;
        m_owner = w;
      end else if (m_done && (m_owner ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  end

  bit rsp_rand = 0;
  always @(posedge clock) begin
    #2;
    if (rsp_rand) begin
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
  end

  bit hs0, hs1;
  task automatic cycle();
    @(negedge clock);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input bit ch, input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(ch ? hs1 : hs0) && n < budget);
    chk("grant_timeout", 32'(ch ? hs1 : hs0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] held;
  bit last_g;
  int grants, n1;

  initial begin
    aclr = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_dataa = 0; req1_dataa = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr", 32'(core_clr), 32'd1);
    chk("rst_en", 32'(core_clk_en), 32'd0);
    chk("rst_dataa", core_dataa, 32'd0);
    chk("rst_res0", rsp0_result, 32'd0);
    chk("rst_res1", rsp1_result, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    aclr = 1'b1;

    // Single job on requester 0
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_dataa = 32'h3F800000;
    #1 chk("t1_ready", 32'(req0_ready), 32'd1);
    wait_hs(0, 10);
    req0_valid = 0;
    wait_idle(100);

    // Both valid continuously: grants alternate
    req0_valid = 1; req0_dataa = $urandom;
    req1_valid = 1; req1_dataa = $urandom;
    grants = 0;
    for (int i = 0; i < 300 && grants < 8; i++) begin
      cycle();
      if (hs0 || hs1) begin
        if (grants > 0) chk("alternate", 32'(hs1), 32'(!last_g));
        last_g = hs1;
        grants++;
        if (hs0) req0_dataa = $urandom;
        if (hs1) req1_dataa = $urandom;
      end
    end
    chk("alt_grants", 32'(grants), 32'd8);
    req0_valid = 0; req1_valid = 0;
    wait_idle(100);

    // Hold DONE on requester 1
    rsp1_ready = 0;
    req1_valid = 1; req1_dataa = $urandom;
    wait_hs(1, 10);
    req1_valid = 0;
    for (int i = 0; i < 50 && !rsp1_valid; i++) cycle();
    chk("hold_valid", 32'(rsp1_valid), 32'd1);
    held = rsp1_result;
    repeat (20) cycle();
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_result", rsp1_result, held);
    rsp1_ready = 1;
    cycle();
    chk("hold_release", 32'(busy), 32'd0);

    // Requester 1 pulses while busy and is never served
    req0_valid = 1; req0_dataa = $urandom;
    wait_hs(0, 10);
    req0_valid = 0;
    repeat (2) cycle();
    req1_valid = 1; req1_dataa = $urandom;
    n1 = 0;
    cycle();
    if (hs1) n1++;
    req1_valid = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (hs1) n1++;
    end
    chk("pulse_no_grant", 32'(n1), 32'd0);

    // Randomised traffic with random response back-pressure
    rsp_rand = 1;
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (hs0) begin
        if ($urandom_range(0, 1) != 0) req0_dataa = $urandom;
        else req0_valid = 0;
      end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1; req0_dataa = $urandom;
      end
      if (hs1) begin
        if ($urandom_range(0, 1) != 0) req1_dataa = $urandom;
        else req1_valid = 0;
      end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1; req1_dataa = $urandom;
      end
    end
    req0_valid = 0; req1_valid = 0;
    rsp_rand = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    wait_idle(100);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of RUN
    req0_valid = 1; req0_dataa = $urandom;
    wait_hs(0, 10);
    req1_valid = 1; req1_dataa = $urandom;
    repeat (5) cycle();
    chk("mid_run_en", 32'(core_clk_en), 32'd1);
    #2 aclr = 1'b0;
    #1;
    chk("ar_clr", 32'(core_clr), 32'd1);
    chk("ar_en", 32'(core_clk_en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_valids", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("ar_readies", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clock);
    #1 aclr = 1'b1;
    #1 chk("ar_tie_grant", 32'({req1_ready, req0_ready}), 32'd1);
    cycle();
    req0_valid = 0; req1_valid = 0;
    wait_idle(100);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_cos_scheduler.md
Name: cordic_cos_scheduler

Overview:
- Sequencing controller and two-requester round-robin arbiter for the shared iterative CORDIC cosine core (clock/aclr/clk_en/dataa/result interface, one rotation per enabled cycle).
- Accepts IEEE-754 single-precision operands on two valid/ready request channels and latches the winning operand into the core.
- Holds the core in clear, then enables it for exactly LATENCY cycles, captures the result, and returns it on the winner's valid/ready response channel.
- Sits between the processor-side custom-instruction glue and the core.

Parameters:
- LATENCY, 10, enabled core cycles per job before the result is sampled; legal range 1..255.
- CNT_W, 8, width of the iteration counter; must satisfy 2^CNT_W > LATENCY.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- aclr  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand.
- req0_dataa  in  32  requester 0 float operand (radians).
- req0_ready  out  1  requester 0 operand accepted this cycle.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_result  out  32  requester 0 result.
- rsp0_ready  in  1  requester 0 consumes the result.
- req1_valid, req1_dataa, req1_ready, rsp1_valid, rsp1_result, rsp1_ready: same as channel 0, for requester 1.
- core_clr  out  1  active-high clear to the core's aclr.
- core_clk_en  out  1  core clk_en.
- core_dataa  out  32  registered operand to the core.
- core_result  in  32  core result.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the requester currently served; meaningful only while busy.

Behaviour:
- State machine with four states: IDLE, LOAD, RUN, DONE.
- Reset (aclr low, asynchronous, any state including mid-job):
  - state goes to IDLE; counter to 0; round-robin pointer favours requester 0.
  - core_dataa, rsp result registers and owner go to 0.
  - Outputs during reset: core_clr=1, core_clk_en=0, all ready/valid=0, busy=0.
  - An in-flight job is discarded and no response is issued.
- IDLE:
  - core_clr=1, core_clk_en=0.
  - reqN_ready is combinational: high only for the arbitration winner, and only when that winner's valid is high.
  - Arbitration: if only one requester is valid, it wins. If both are valid, the requester not served last wins; the first tie after reset goes to requester 0.
  - On a handshake (valid & ready): latch dataa into core_dataa, set owner, go to LOAD.
  - No valid: stay in IDLE.
- LOAD (exactly 1 cycle): core_clr=1, core_clk_en=0, counter cleared; go to RUN.
- RUN:
  - core_clr=0, core_clk_en=1; counter increments every cycle.
  - When counter == LATENCY-1: capture core_result into the owner's result register, update the round-robin pointer to owner, go to DONE.
  - RUN therefore lasts exactly LATENCY cycles.
- DONE:
  - core_clr=0, core_clk_en=0, so the core holds its final state.
  - rsp<owner>_valid=1; rsp<owner>_result is stable; the other channel's rsp_valid=0.
  - On rsp<owner>_ready: go to IDLE. Without it, stay in DONE indefinitely.
- Latency: if a request is accepted at edge E, rsp_valid rises after edge E+LATENCY+1. With rsp_ready held high, the next request can be accepted at edge E+LATENCY+3 (one IDLE cycle between jobs).
- A requester that deasserts valid before it is granted is simply not served; no state is retained for it.
- Requests arriving while busy are back-pressured (ready=0); valid and dataa must be held until accepted.
- rspN_result holds its last captured value after a response completes; it is only overwritten by a new capture or by reset.
- The controller performs no arithmetic on data: operand and result pass through unmodified.

Test Plan:
- Reset with LATENCY=10; drive req0_valid=1, req0_dataa=0x3F800000 at edge 0 -> req0_ready high in cycle 0; core_clr low and core_clk_en high for exactly 10 cycles; rsp0_valid rises after edge 11; rsp0_result equals the core_result sampled on the last RUN edge.
- Both valid continuously, rsp_ready tied high -> grants alternate 0,1,0,1; first grant goes to 0; the two channels' ready signals are never high together.
- Hold rsp1_ready=0 for 20 cycles while in DONE -> busy stays 1, rsp1_valid and rsp1_result stay stable, both req_ready signals stay 0; releasing rsp1_ready gives IDLE on the next edge.
- Pull aclr low during cycle 5 of RUN -> outputs immediately read core_clr=1, core_clk_en=0, busy=0, all valid signals 0; after aclr releases, a tie is granted to requester 0.
- LATENCY=1 build -> exactly one core_clk_en cycle; rsp_valid rises after edge 2.
- req1_valid pulsed high for one cycle while busy, then dropped -> requester 1 is never granted and rsp1_valid is never asserted.
